// File: rtl/pwm_pkg.sv
// Shared constants and state encoding for the PWM generator.
package pwm_pkg;

    localparam int PWM_WIDTH      = 8;
    localparam int PWM_RST_PERIOD = 255;
    localparam int PWM_RST_DUTY   = 0;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } pwm_state_e;

endpackage

// File: rtl/pwm_shadow_reg.sv
// Pending/active double buffer for period and duty.
// Pending values become active only at a period boundary or while idle.
module pwm_shadow_reg
    import pwm_pkg::*;
#(
    parameter int WIDTH      = PWM_WIDTH,
    parameter int RST_PERIOD = PWM_RST_PERIOD,
    parameter int RST_DUTY   = PWM_RST_DUTY
) (
    input  logic             ck,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_period,
    input  logic [WIDTH-1:0] i_duty,
    input  logic             i_bound,
    input  logic             i_idle,
    output logic [WIDTH-1:0] o_per_act,
    output logic [WIDTH-1:0] o_duty_act,
    output logic             o_pend,
    output logic             o_ack
);

    logic [WIDTH-1:0] r_pend_per;
    logic [WIDTH-1:0] r_pend_duty;
    logic [WIDTH-1:0] r_per_act;
    logic [WIDTH-1:0] r_duty_act;
    logic             r_pend;
    logic             r_ack;
    logic             w_xfer;

    // A load on the boundary edge itself bypasses straight into active
    assign w_xfer = (i_bound & (r_pend | i_load)) | (i_idle & r_pend);

    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            r_pend_per  <= '0;
            r_pend_duty <= '0;
            r_per_act   <= WIDTH'(RST_PERIOD);
            r_duty_act  <= WIDTH'(RST_DUTY);
            r_pend      <= 1'b0;
            r_ack       <= 1'b0;
        end else begin
            r_ack <= w_xfer;
            if (w_xfer) begin
                r_per_act  <= i_load ? i_period : r_pend_per;
                r_duty_act <= i_load ? i_duty   : r_pend_duty;
                r_pend     <= 1'b0;
            end else if (i_load) begin
                r_pend_per  <= i_period;
                r_pend_duty <= i_duty;
                r_pend      <= 1'b1;
            end
        end
    end

    assign o_per_act  = r_per_act;
    assign o_duty_act = r_duty_act;
    assign o_pend     = r_pend;
    assign o_ack      = r_ack;

endmodule

// File: rtl/pwm_gen_core.sv
// Free-running PWM generator: counter, run/idle FSM and registered compare.
module pwm_gen_core
    import pwm_pkg::*;
#(
    parameter int WIDTH      = PWM_WIDTH,
    parameter int RST_PERIOD = PWM_RST_PERIOD,
    parameter int RST_DUTY   = PWM_RST_DUTY
) (
    input  logic             ck,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] period_i,
    input  logic [WIDTH-1:0] duty_i,
    input  logic             load,
    output logic             load_ack,
    output logic             pend_o,
    output logic             pwm_raw,
    output logic             cyc_start,
    output logic [WIDTH-1:0] cnt_o
);

    pwm_state_e       r_state;
    pwm_state_e       w_state_nxt;
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] w_cnt_nxt;
    logic             r_pwm;
    logic             r_cyc;
    logic             w_pwm_nxt;
    logic             w_cyc_nxt;
    logic [WIDTH-1:0] w_per_act;
    logic [WIDTH-1:0] w_duty_act;
    logic             w_wrap;
    logic             w_idle;

    assign w_idle = (r_state == IDLE);
    assign w_wrap = (r_state == RUN) && (r_cnt == w_per_act);

    pwm_shadow_reg #(
        .WIDTH      (WIDTH),
        .RST_PERIOD (RST_PERIOD),
        .RST_DUTY   (RST_DUTY)
    ) u_shadow (
        .ck         (ck),
        .rst        (rst),
        .i_load     (load),
        .i_period   (period_i),
        .i_duty     (duty_i),
        .i_bound    (w_wrap),
        .i_idle     (w_idle),
        .o_per_act  (w_per_act),
        .o_duty_act (w_duty_act),
        .o_pend     (pend_o),
        .o_ack      (load_ack)
    );

    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Leaving RUN zeroes the counter on the same edge
    always_comb begin
        w_state_nxt = en ? RUN : IDLE;
        w_cnt_nxt   = '0;
        w_pwm_nxt   = 1'b0;
        w_cyc_nxt   = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_cnt_nxt = '0;
            end
            RUN: begin
                w_pwm_nxt = (r_cnt < w_duty_act);
                w_cyc_nxt = (r_cnt == '0);
                if (en && !w_wrap) begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            r_pwm <= 1'b0;
            r_cyc <= 1'b0;
        end else begin
            r_cnt <= w_cnt_nxt;
            r_pwm <= w_pwm_nxt;
            r_cyc <= w_cyc_nxt;
        end
    end

    assign pwm_raw   = r_pwm;
    assign cyc_start = r_cyc;
    assign cnt_o     = r_cnt;

endmodule

// File: tb/tb_pwm_gen_core.sv
// Self-checking bench for pwm_gen_core: per-edge scoreboard
// against a behavioural model plus direct waveform checks.
module tb_pwm_gen_core;

    localparam int W = 8;
    typedef logic [W+3:0] obs_t;

    logic         ck = 1'b0;
    logic         rst = 1'b1;
    logic         en = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] period_i = '0;
    logic [W-1:0] duty_i = '0;
    logic         load_ack;
    logic         pend_o;
    logic         pwm_raw;
    logic         cyc_start;
    logic [W-1:0] cnt_o;

    int   checks = 0;
    int   errors = 0;
    obs_t sb[$];

    logic [W-1:0] m_cnt, m_per, m_duty, m_pper, m_pduty;
    logic         m_run, m_pend, m_ack, m_pwm, m_cyc;

    pwm_gen_core #(
        .WIDTH      (W),
        .RST_PERIOD (255),
        .RST_DUTY   (0)
    ) dut (
        .ck        (ck),
        .rst       (rst),
        .en        (en),
        .period_i  (period_i),
        .duty_i    (duty_i),
        .load      (load),
        .load_ack  (load_ack),
        .pend_o    (pend_o),
        .pwm_raw   (pwm_raw),
        .cyc_start (cyc_start),
        .cnt_o     (cnt_o)
    );

    always #5 ck = ~ck;

    task automatic model_reset();
        m_cnt   = '0;
        m_per   = 8'd255;
        m_duty  = 8'd0;
        m_pper  = '0;
        m_pduty = '0;
        m_run   = 1'b0;
        m_pend  = 1'b0;
        m_ack   = 1'b0;
        m_pwm   = 1'b0;
        m_cyc   = 1'b0;
    endtask

    // One rising edge: advance the model, then queue its expected outputs
    task automatic tick();
        logic wrap, xfer;
        @(posedge ck);
        if (rst) begin
            model_reset();
        end else begin
            wrap  = m_run && (m_cnt == m_per);
            xfer  = m_run ? (wrap && (m_pend || load)) : m_pend;
            m_pwm = m_run && (m_cnt < m_duty);
            m_cyc = m_run && (m_cnt == 0);
            m_cnt = (!m_run || !en || wrap) ? '0 : m_cnt + 1'b1;
            m_run = en;
            m_ack = xfer;
            if (xfer) begin
                m_per  = load ? period_i : m_pper;
                m_duty = load ? duty_i : m_pduty;
                m_pend = 1'b0;
            end else if (load) begin
                m_pper  = period_i;
                m_pduty = duty_i;
                m_pend  = 1'b1;
            end
        end
        #1;
        sb.push_back({m_cnt, m_pwm, m_cyc, m_ack, m_pend});
    endtask

    task automatic test_reset();
        obs_t e, g;
        int hi, cs;
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i == 2) rst = 1'b0;
            if (i == 2) begin load = 1'b1; period_i = 9; duty_i = 8; end
            if (i == 3) load = 1'b0;
            if (i == 4) en = 1'b1;
            tick();
            e = sb.pop_front();
            g = {cnt_o, pwm_raw, cyc_start, load_ack, pend_o};
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL reset_seq step %0d: got %h exp %h", i, g, e);
            end
        end
        checks++;
        if (cnt_o !== 8'd5 || pwm_raw !== 1'b1) begin
            errors++;
            $display("FAIL reset_pre: cnt %0d pwm %b, want 5 1", cnt_o, pwm_raw);
        end
        #3 rst = 1'b1;
        #1;
        checks++;
        if (cnt_o !== 8'd0) begin
            errors++;
            $display("FAIL async_cnt: got %0d exp 0", cnt_o);
        end
        checks++;
        if (pwm_raw !== 1'b0 || cyc_start !== 1'b0) begin
            errors++;
            $display("FAIL async_pwm: got %b%b exp 00", pwm_raw, cyc_start);
        end
        checks++;
        if (pend_o !== 1'b0 || load_ack !== 1'b0) begin
            errors++;
            $display("FAIL async_shadow: got %b%b exp 00", pend_o, load_ack);
        end
        hi = 0;
        cs = 0;
        for (int t = 0; t <= 512; t++) begin
            tick();
            if (t == 0) rst = 1'b0;
            e = sb.pop_front();
            g = {cnt_o, pwm_raw, cyc_start, load_ack, pend_o};
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL reset_run t%0d: got %h exp %h", t, g, e);
            end
            if (t > 0) begin
                hi += int'(pwm_raw);
                cs += int'(cyc_start);
            end
        end
        checks++;
        if (hi != 0) begin
            errors++;
            $display("FAIL reset_duty0: high cycles %0d exp 0", hi);
        end
        checks++;
        if (cs != 2) begin
            errors++;
            $display("FAIL reset_period256: starts %0d exp 2", cs);
        end
    endtask

    task automatic test_basic();
        obs_t e, g;
        logic xp, xc;
        en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 2) begin load = 1'b1; period_i = 9; duty_i = 3; end
            if (i == 3) load = 1'b0;
            tick();
            e = sb.pop_front();
            g = {cnt_o, pwm_raw, cyc_start, load_ack, pend_o};
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL basic_load step %0d: got %h exp %h", i, g, e);
            end
        end
        checks++;
        if (load_ack !== 1'b1) begin
            errors++;
            $display("FAIL basic_ack: got %b exp 1", load_ack);
        end
        en = 1'b1;
        for (int t = 1; t <= 41; t++) begin
            tick();
            e = sb.pop_front();
            g = {cnt_o, pwm_raw, cyc_start, load_ack, pend_o};
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL basic_sb t%0d: got %h exp %h", t, g, e);
            end
            if (t >= 2) begin
                xp = ((t - 2) % 10) < 3;
                xc = ((t - 2) % 10) == 0;
                checks++;
                if (pwm_raw !== xp || cyc_start !== xc) begin
                    errors++;
                    $display("FAIL basic_wave t%0d: got %b%b exp %b%b",
                             t, pwm_raw, cyc_start, xp, xc);
                end
            end
        end
    endtask

    task automatic test_mid_update();
        obs_t e, g;
        logic xp;
        for (int k = 0; k < 12 && m_cnt != 4; k++) begin
            tick();
            e = sb.pop_front();
            g = {cnt_o, pwm_raw, cyc_start, load_ack, pend_o};
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL mid_sync: got %h exp %h", g, e);
            end
        end
        for (int j = 0; j <= 15; j++) begin
            load = (j == 0) || (j == 2);
            period_i = 9;
            duty_i = (j == 0) ? 8'd7 : 8'd5;
            tick();
            load = 1'b0;
            e = sb.pop_front();
            g = {cnt_o, pwm_raw, cyc_start, load_ack, pend_o};
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL mid_sb j%0d: got %h exp %h", j, g, e);
            end
            checks++;
            if (load_ack !== (j == 5) || pend_o !== (j < 5)) begin
                errors++;
                $display("FAIL mid_ack j%0d: got ack %b pend %b", j, load_ack, pend_o);
            end
            xp = (j >= 6) && ((j - 6) < 5);
            checks++;
            if (pwm_raw !== xp) begin
                errors++;
                $display("FAIL mid_pwm j%0d: got %b exp %b", j, pwm_raw, xp);
            end
        end
    endtask

    task automatic test_extremes();
        obs_t e, g;
        int duties[3] = '{0, 10, 255};
        foreach (duties[d]) begin
            for (int k = 0; k < 38; k++) begin
                load = (k == 0);
                period_i = 9;
                duty_i = W'(duties[d]);
                tick();
                load = 1'b0;
                e = sb.pop_front();
                g = {cnt_o, pwm_raw, cyc_start, load_ack, pend_o};
                checks++;
                if (g !== e) begin
                    errors++;
                    $display("FAIL ext_sb d%0d k%0d: got %h exp %h", duties[d], k, g, e);
                end
                if (k >= 13 || duties[d] == 255) begin
                    checks++;
                    if (pwm_raw !== (duties[d] != 0)) begin
                        errors++;
                        $display("FAIL ext_const d%0d k%0d: got %b", duties[d], k, pwm_raw);
                    end
                end
            end
        end
    endtask

    task automatic test_period0();
        obs_t e, g;
        for (int k = 0; k < 23; k++) begin
            load = (k == 0);
            period_i = 0;
            duty_i = 1;
            tick();
            load = 1'b0;
            e = sb.pop_front();
            g = {cnt_o, pwm_raw, cyc_start, load_ack, pend_o};
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL p0_sb k%0d: got %h exp %h", k, g, e);
            end
            if (k >= 13) begin
                checks++;
                if (pwm_raw !== 1'b1 || cyc_start !== 1'b1) begin
                    errors++;
                    $display("FAIL p0_const k%0d: got %b%b exp 11", k, pwm_raw, cyc_start);
                end
            end
        end
        for (int k = 0; k < 3; k++) begin
            load = (k == 0);
            duty_i = 0;
            tick();
            load = 1'b0;
            e = sb.pop_front();
            g = {cnt_o, pwm_raw, cyc_start, load_ack, pend_o};
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL p0_zero_sb k%0d: got %h exp %h", k, g, e);
            end
            checks++;
            if (load_ack !== (k == 0) || pend_o !== 1'b0) begin
                errors++;
                $display("FAIL p0_ack k%0d: got ack %b pend %b", k, load_ack, pend_o);
            end
            checks++;
            if (pwm_raw !== (k == 0) || cyc_start !== 1'b1) begin
                errors++;
                $display("FAIL p0_pwm k%0d: got %b%b", k, pwm_raw, cyc_start);
            end
        end
    endtask

    task automatic test_back_to_back();
        obs_t e, g;
        for (int k = 0; k < 16 && !(k > 2 && m_cnt == 9); k++) begin
            load = (k == 0);
            period_i = 9;
            duty_i = 3;
            tick();
            load = 1'b0;
            e = sb.pop_front();
            g = {cnt_o, pwm_raw, cyc_start, load_ack, pend_o};
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL b2b_sync k%0d: got %h exp %h", k, g, e);
            end
        end
        for (int j = 0; j <= 15; j++) begin
            load = (j == 0);
            duty_i = 6;
            en = (j < 15);
            tick();
            load = 1'b0;
            e = sb.pop_front();
            g = {cnt_o, pwm_raw, cyc_start, load_ack, pend_o};
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL b2b_sb j%0d: got %h exp %h", j, g, e);
            end
            checks++;
            if (load_ack !== (j == 0) || pend_o !== 1'b0) begin
                errors++;
                $display("FAIL b2b_ack j%0d: got ack %b pend %b", j, load_ack, pend_o);
            end
            if (j >= 1 && j <= 10) begin
                checks++;
                if (pwm_raw !== ((j - 1) < 6)) begin
                    errors++;
                    $display("FAIL b2b_pwm j%0d: got %b", j, pwm_raw);
                end
            end
        end
        checks++;
        if (cnt_o !== 8'd0 || pwm_raw !== 1'b1) begin
            errors++;
            $display("FAIL stop_edge: cnt %0d pwm %b, want 0 1", cnt_o, pwm_raw);
        end
        tick();
        e = sb.pop_front();
        g = {cnt_o, pwm_raw, cyc_start, load_ack, pend_o};
        checks++;
        if (g !== e || pwm_raw !== 1'b0 || cnt_o !== 8'd0) begin
            errors++;
            $display("FAIL stop_after: got %h exp %h", g, e);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_mid_update();
        test_extremes();
        test_period0();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
